diff_stage: RTL and testbench
=============================

Name: diff_stage

Overview:
- Upstream neighbour of the AR stage: applies d-th order differencing (the "I" of ARIMA) to the raw input series.
- Emits a stationary stream that the AR/MA stages consume.
- Exports the history anchors that the downstream inverse-differencing stage needs to rebuild the forecast.
- Data format is the codebase's signed-magnitude fixed point, Q(N-1-Q).Q, the same format used by qadd/qmult.

Parameters:
- N, 32, total data width including the sign bit.
- Q, 15, number of fractional bits.
- D_MAX, 2, maximum supported differencing order; one cascaded difference stage per order.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- rst  in  1  reset; synchronous, active-high.
- cfg_load  in  1  single-cycle strobe; latches d_order_in and clears all history.
- d_order_in  in  32  requested differencing order.
- in_valid  in  1  input sample valid.
- in_ready  out  1  block can accept a sample this cycle.
- in_data  in  N  raw sample, signed-magnitude.
- out_valid  out  1  differenced sample valid.
- out_ready  in  1  consumer accepts out_data.
- out_data  out  N  differenced sample, signed-magnitude.
- out_sat  out  1  out_data was saturated; qualified by out_valid.
- anchor_0  out  N  last accepted raw sample x[n].
- anchor_1  out  N  last first difference x[n]-x[n-1]; 0 until it exists.
- d_order  out  2  active order in use.
- cfg_err  out  1  sticky flag: last cfg_load requested an order above D_MAX.

Behaviour:
- Reset values:
  - out_valid=0, out_data=0, out_sat=0.
  - anchor_0=0, anchor_1=0.
  - d_order=0, cfg_err=0.
  - All stage history registers and primed flags cleared.
- Handshake:
  - in_ready = !cfg_load && (!out_valid || out_ready).
  - A sample is accepted when in_valid && in_ready.
  - While out_valid && !out_ready, out_data and out_sat hold stable.
- Stage k (k=1..D_MAX):
  - Holds prev_k and primed_k.
  - On accept: y_k = y_{k-1} - prev_k; prev_k <= y_{k-1}; primed_k <= 1.
  - y_0 = in_data.
  - A stage that is not primed produces no output; it only captures prev_k.
- Order selection:
  - Output is y_d with d = d_order.
  - d=0: registered pass-through.
  - Stages above d are not updated.
- Latency: 1 cycle. For an accept at edge t, out_valid=1 after edge t, provided all stages 1..d were primed before t.
- Warm-up: after rst or cfg_load, the first d accepted samples give no output (out_valid stays 0). Sample d+1 gives the first output.
- Subtraction:
  - Computed as signed-magnitude a + (-b) at N+1 bits internally.
  - Magnitude above 2^(N-1)-1 saturates to ±(2^(N-1)-1) with out_sat=1; otherwise out_sat=0.
  - Negative zero is normalised to +0.
- Anchors:
  - On every accept, anchor_0 <= in_data.
  - anchor_1 <= y_1 once stage 1 is primed.
  - Anchors update even when d=0.
- cfg_load:
  - Takes priority over a simultaneous in_valid; no accept that cycle.
  - Any pending out_valid is dropped.
  - History and anchors are cleared.
  - d_order <= min(d_order_in, D_MAX).
  - cfg_err <= (d_order_in > D_MAX).
- rst mid-stream: on the next edge everything returns to reset values, including dropping a pending output. in_ready is 0 while rst=1.
- Back-to-back operation: a new accept in the same cycle as out_ready=1 replaces the output, with no bubble.

Decomposition:
- Shared package arima_pkg holds:
  - Localparams N, Q, D_MAX.
  - Typedef sample_t (logic [N-1:0]).
  - Helper functions sm_neg (flip sign bit) and sm_is_zero.
- Sub-module qsub_sat:
  - Combinational signed-magnitude a-b with saturation.
  - Outputs result and sat.
  - Instantiated D_MAX times in a generate loop.

Test Plan:
- Order 1: cfg_load d=1; feed 1.0 (0x00008000), 3.0 (0x00018000), 2.0 (0x00010000) -> no output for the first sample, then 0x00010000 (2.0), then 0x80008000 (-1.0). anchor_0=0x00010000 at the end.
- Order 2: cfg_load d=2; feed 1,4,9,16 (×0x8000) -> first two give no output, then 0x00010000 twice. anchor_1=0x00038000 (7.0).
- Backpressure: d=0; hold out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, out_data stable. On release, next sample follows with no gap and no loss.
- Saturation: d=1; feed 0xFFFFFFFF then 0x7FFFFFFF -> out_data=0x7FFFFFFF, out_sat=1.
- Config error and clamp: cfg_load with d_order_in=3 -> d_order=2, cfg_err=1. Next cfg_load d=1 -> cfg_err=0.
- Mid-stream reset: d=2 primed with a pending output; assert rst one cycle -> out_valid=0, anchors=0. Restart requires 2 warm-up samples again.

Source files
------------

// File: rtl/arima_pkg.sv
// Shared ARIMA datapath definitions: sample format and signed-magnitude helpers.
`default_nettype none
package arima_pkg;
  localparam int N     = 32;
  localparam int Q     = 15;
  localparam int D_MAX = 2;
  localparam int DW    = $clog2(D_MAX + 1);

  typedef logic [N-1:0] sample_t;

  function automatic sample_t sm_neg(input sample_t a);
    return {~a[N-1], a[N-2:0]};
  endfunction

  function automatic logic sm_is_zero(input sample_t a);
    return (a[N-2:0] == '0);
  endfunction
endpackage
`default_nettype wire

// File: rtl/diff_stage_if.sv
// Streaming input/output handshake bundle for diff_stage.
`default_nettype none
interface diff_stage_if;
  import arima_pkg::*;

  logic    in_valid;
  logic    in_ready;
  sample_t in_data;
  logic    out_valid;
  logic    out_ready;
  sample_t out_data;
  logic    out_sat;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_sat
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_sat
  );
endinterface
`default_nettype wire

// File: rtl/qsub_sat.sv
// Combinational signed-magnitude a - b with saturation to the largest magnitude.
`default_nettype none
module qsub_sat
  import arima_pkg::*;
(
  input  sample_t a,
  input  sample_t b,
  output sample_t result,
  output logic    sat
);
  sample_t       w_nb;
  logic          w_sa;
  logic          w_sb;
  logic          w_sign;
  logic [N-1:0]  w_ma;
  logic [N-1:0]  w_mb;
  logic [N-1:0]  w_mag;

  always_comb begin
    w_nb = sm_neg(b);
    w_sa = a[N-1];
    w_sb = w_nb[N-1];
    w_ma = {1'b0, a[N-2:0]};
    w_mb = {1'b0, w_nb[N-2:0]};
    if (w_sa == w_sb) begin
      w_mag  = w_ma + w_mb;
      w_sign = w_sa;
    end else if (w_ma >= w_mb) begin
      w_mag  = w_ma - w_mb;
      w_sign = w_sa;
    end else begin
      w_mag  = w_mb - w_ma;
      w_sign = w_sb;
    end

    sat = w_mag[N-1];
    if (sat) begin
      result = {w_sign, {(N-1){1'b1}}};
    end else begin
      result = {w_sign, w_mag[N-2:0]};
      // Never emit negative zero.
      if (sm_is_zero(result)) result = '0;
    end
  end
endmodule
`default_nettype wire

// File: rtl/diff_stage.sv
// d-th order differencing front end of the ARIMA pipeline with history anchors
// for the downstream inverse-differencing stage.
`default_nettype none
module diff_stage
  import arima_pkg::*;
(
  input  wire logic          clk,
  input  wire logic          rst,
  input  wire logic          cfg_load,
  input  wire logic [31:0]   d_order_in,
  diff_stage_if.slave        bus,
  output sample_t            anchor_0,
  output sample_t            anchor_1,
  output logic [DW-1:0]      d_order,
  output logic               cfg_err
);
  logic [D_MAX:1][N-1:0] r_prev;
  logic [D_MAX:1]        r_primed;

  logic [D_MAX:0][N-1:0] w_y;
  logic [D_MAX:0]        w_sat;
  logic [D_MAX:0]        w_chain;
  logic                  w_accept;
  logic [DW-1:0]         w_top;
  sample_t               w_sel_data;
  logic                  w_sel_sat;
  logic                  w_sel_ok;

  assign w_y[0]   = bus.in_data;
  assign w_sat[0] = 1'b0;

  generate
    for (genvar k = 1; k <= D_MAX; k++) begin : g_stage
      qsub_sat u_sub (
        .a      (w_y[k-1]),
        .b      (r_prev[k]),
        .result (w_y[k]),
        .sat    (w_sat[k])
      );
    end
  endgenerate

  assign bus.in_ready = !rst && !cfg_load && (!bus.out_valid || bus.out_ready);
  assign w_accept     = bus.in_valid && bus.in_ready;

  // Stage 1 always runs because it also produces anchor_1, even at order 0.
  assign w_top = (d_order == '0) ? DW'(1) : d_order;

  always_comb begin
    w_chain[0] = 1'b1;
    for (int k = 1; k <= D_MAX; k++) begin
      w_chain[k] = w_chain[k-1] & r_primed[k];
    end
    w_sel_data = w_y[0];
    w_sel_sat  = 1'b0;
    w_sel_ok   = 1'b1;
    for (int k = 1; k <= D_MAX; k++) begin
      if (k == int'(d_order)) begin
        w_sel_data = w_y[k];
        w_sel_sat  = w_sat[k];
        w_sel_ok   = w_chain[k];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_prev        <= '0;
      r_primed      <= '0;
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
      bus.out_sat   <= 1'b0;
      anchor_0      <= '0;
      anchor_1      <= '0;
      d_order       <= '0;
      cfg_err       <= 1'b0;
    end else if (cfg_load) begin
      r_prev        <= '0;
      r_primed      <= '0;
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
      bus.out_sat   <= 1'b0;
      anchor_0      <= '0;
      anchor_1      <= '0;
      d_order       <= (d_order_in > 32'(D_MAX)) ? DW'(D_MAX) : d_order_in[DW-1:0];
      cfg_err       <= (d_order_in > 32'(D_MAX));
    end else if (w_accept) begin
      // A stage only sees data once every stage below it is primed.
      for (int k = 1; k <= D_MAX; k++) begin
        if (k <= int'(w_top) && w_chain[k-1]) begin
          r_prev[k]   <= w_y[k-1];
          r_primed[k] <= 1'b1;
        end
      end
      bus.out_valid <= w_sel_ok;
      if (w_sel_ok) begin
        bus.out_data <= w_sel_data;
        bus.out_sat  <= w_sel_sat;
      end
      anchor_0 <= bus.in_data;
      if (r_primed[1]) anchor_1 <= w_y[1];
    end else if (bus.out_ready) begin
      bus.out_valid <= 1'b0;
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_diff_stage.sv
// Self-checking bench for diff_stage: directed scenarios plus a randomized run
// against a sample-history reference model.
`default_nettype none
module tb_diff_stage;
  import arima_pkg::*;

  localparam longint MAXV = 64'h7FFF_FFFF;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cfg_load = 1'b0;
  logic [31:0] d_order_in = '0;
  sample_t     anchor_0;
  sample_t     anchor_1;
  logic [1:0]  d_order;
  logic        cfg_err;

  int n_tests = 0;
  int n_fail  = 0;

  longint hist[$];

  diff_stage_if bus ();

  diff_stage dut (
    .clk        (clk),
    .rst        (rst),
    .cfg_load   (cfg_load),
    .d_order_in (d_order_in),
    .bus        (bus.slave),
    .anchor_0   (anchor_0),
    .anchor_1   (anchor_1),
    .d_order    (d_order),
    .cfg_err    (cfg_err)
  );

  always #5 clk = ~clk;

  function automatic longint sm_to_int(input logic [31:0] x);
    longint m;
    m = longint'(x[30:0]);
    return x[31] ? -m : m;
  endfunction

  function automatic logic [31:0] int_to_sm(input longint v);
    longint m;
    if (v == 0) return 32'h0;
    m = (v < 0) ? -v : v;
    return {(v < 0), m[30:0]};
  endfunction

  function automatic longint clampv(input longint v);
    if (v > MAXV) return MAXV;
    if (v < -MAXV) return -MAXV;
    return v;
  endfunction

  // d-th difference of the newest d+1 samples, clamping at every level.
  function automatic longint model_diff(input int d, output bit sat);
    longint v[3];
    longint raw;
    sat = 1'b0;
    for (int i = 0; i <= d; i++) v[i] = hist[hist.size() - 1 - d + i];
    for (int l = 1; l <= d; l++) begin
      for (int i = 0; i <= d - l; i++) begin
        raw  = v[i+1] - v[i];
        sat  = (raw > MAXV) || (raw < -MAXV);
        v[i] = clampv(raw);
      end
    end
    return v[0];
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg(input logic [31:0] d);
    cfg_load   = 1'b1;
    d_order_in = d;
    step();
    cfg_load   = 1'b0;
  endtask

  task automatic send(input logic [31:0] x);
    bus.in_valid = 1'b1;
    bus.in_data  = x;
    step();
    bus.in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    n_tests++;
    if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 0", bus.in_ready); end
    n_tests++;
    if ({bus.out_valid, bus.out_sat, bus.out_data} !== '0) begin
      n_fail++; $display("FAIL reset_out: got v=%b s=%b d=%h expected all 0", bus.out_valid, bus.out_sat, bus.out_data);
    end
    n_tests++;
    if ({anchor_0, anchor_1, d_order, cfg_err} !== '0) begin
      n_fail++; $display("FAIL reset_state: got a0=%h a1=%h d=%0d err=%b expected all 0", anchor_0, anchor_1, d_order, cfg_err);
    end
    rst = 1'b0;
    #1;
    n_tests++;
    if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL idle_in_ready: got %b expected 1", bus.in_ready); end
  endtask

  task automatic test_order1();
    cfg(1);
    send(32'h0000_8000);
    n_tests++;
    if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL o1_warmup: got valid %b expected 0", bus.out_valid); end
    send(32'h0001_8000);
    n_tests++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== 32'h0001_0000) begin
      n_fail++; $display("FAIL o1_first: got v=%b d=%h expected v=1 d=00010000", bus.out_valid, bus.out_data);
    end
    send(32'h0001_0000);
    n_tests++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== 32'h8000_8000 || bus.out_sat !== 1'b0) begin
      n_fail++; $display("FAIL o1_neg: got v=%b d=%h s=%b expected v=1 d=80008000 s=0", bus.out_valid, bus.out_data, bus.out_sat);
    end
    n_tests++;
    if (anchor_0 !== 32'h0001_0000) begin n_fail++; $display("FAIL o1_anchor0: got %h expected 00010000", anchor_0); end
  endtask

  task automatic test_order2();
    logic [31:0] xs[4];
    xs = '{32'h0000_8000, 32'h0002_0000, 32'h0004_8000, 32'h0008_0000};
    cfg(2);
    for (int i = 0; i < 4; i++) begin
      send(xs[i]);
      n_tests++;
      if (i < 2) begin
        if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL o2_warmup[%0d]: got valid %b expected 0", i, bus.out_valid); end
      end else if (bus.out_valid !== 1'b1 || bus.out_data !== 32'h0001_0000) begin
        n_fail++; $display("FAIL o2_out[%0d]: got v=%b d=%h expected v=1 d=00010000", i, bus.out_valid, bus.out_data);
      end
    end
    n_tests++;
    if (anchor_1 !== 32'h0003_8000) begin n_fail++; $display("FAIL o2_anchor1: got %h expected 00038000", anchor_1); end
  endtask

  task automatic test_backpressure();
    cfg(0);
    bus.out_ready = 1'b0;
    send(32'h1234_5678);
    n_tests++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== 32'h1234_5678) begin
      n_fail++; $display("FAIL bp_first: got v=%b d=%h expected v=1 d=12345678", bus.out_valid, bus.out_data);
    end
    bus.in_valid = 1'b1;
    bus.in_data  = 32'h8765_4321;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_tests++;
      if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1 || bus.out_data !== 32'h1234_5678) begin
        n_fail++; $display("FAIL bp_stall[%0d]: got rdy=%b v=%b d=%h expected rdy=0 v=1 d=12345678", i, bus.in_ready, bus.out_valid, bus.out_data);
      end
      step();
    end
    bus.out_ready = 1'b1;
    #1;
    n_tests++;
    if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release_ready: got %b expected 1", bus.in_ready); end
    step();
    bus.in_valid = 1'b0;
    n_tests++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== 32'h8765_4321) begin
      n_fail++; $display("FAIL bp_next: got v=%b d=%h expected v=1 d=87654321", bus.out_valid, bus.out_data);
    end
    step();
    n_tests++;
    if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_drain: got valid %b expected 0", bus.out_valid); end
  endtask

  task automatic test_saturation();
    cfg(1);
    send(32'hFFFF_FFFF);
    send(32'h7FFF_FFFF);
    n_tests++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== 32'h7FFF_FFFF || bus.out_sat !== 1'b1) begin
      n_fail++; $display("FAIL sat: got v=%b d=%h s=%b expected v=1 d=7fffffff s=1", bus.out_valid, bus.out_data, bus.out_sat);
    end
  endtask

  task automatic test_cfg_err();
    bus.in_valid = 1'b1;
    bus.in_data  = 32'h0000_4000;
    cfg_load     = 1'b1;
    d_order_in   = 32'd3;
    #1;
    n_tests++;
    if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL cfg_priority_ready: got %b expected 0", bus.in_ready); end
    step();
    cfg_load     = 1'b0;
    bus.in_valid = 1'b0;
    n_tests++;
    if (d_order !== 2'd2 || cfg_err !== 1'b1 || anchor_0 !== 32'h0) begin
      n_fail++; $display("FAIL cfg_clamp: got d=%0d err=%b a0=%h expected d=2 err=1 a0=0", d_order, cfg_err, anchor_0);
    end
    cfg(1);
    n_tests++;
    if (d_order !== 2'd1 || cfg_err !== 1'b0) begin
      n_fail++; $display("FAIL cfg_clear_err: got d=%0d err=%b expected d=1 err=0", d_order, cfg_err);
    end
  endtask

  task automatic test_midstream_reset();
    cfg(2);
    send(32'h0000_8000);
    send(32'h0001_0000);
    bus.out_ready = 1'b0;
    send(32'h0002_0000);
    n_tests++;
    if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL mr_pending: got valid %b expected 1", bus.out_valid); end
    rst = 1'b1;
    #1;
    n_tests++;
    if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL mr_ready: got %b expected 0", bus.in_ready); end
    step();
    rst = 1'b0;
    bus.out_ready = 1'b1;
    n_tests++;
    if (bus.out_valid !== 1'b0 || anchor_0 !== 32'h0 || anchor_1 !== 32'h0 || d_order !== 2'd0) begin
      n_fail++; $display("FAIL mr_clear: got v=%b a0=%h a1=%h d=%0d expected all 0", bus.out_valid, anchor_0, anchor_1, d_order);
    end
    cfg(2);
    for (int i = 0; i < 3; i++) begin
      send(32'(i * 32'h0001_0000 + 32'h0000_8000));
      n_tests++;
      if (bus.out_valid !== (i == 2)) begin
        n_fail++; $display("FAIL mr_restart[%0d]: got valid %b expected %b", i, bus.out_valid, (i == 2));
      end
    end
  endtask

  task automatic test_random();
    bit          iv, ordy, exp_ready, acc, exp_valid, exp_sat, s;
    logic [31:0] x, exp_data, exp_a0, exp_a1;
    longint      v;
    for (int d = 0; d <= D_MAX; d++) begin
      bus.out_ready = 1'b1;
      cfg(d);
      hist.delete();
      exp_valid = 1'b0; exp_data = '0; exp_sat = 1'b0; exp_a0 = '0; exp_a1 = '0;
      for (int cyc = 0; cyc < 80; cyc++) begin
        iv   = ($urandom_range(0, 3) != 0);
        ordy = ($urandom_range(0, 3) != 0);
        case ($urandom_range(0, 3))
          0: x = $urandom;
          1: x = {1'($urandom), 15'd0, 16'($urandom)};
          2: x = {1'($urandom), 31'h7FFF_FFFF - 31'($urandom_range(0, 255))};
          default: x = ($urandom_range(0, 1) != 0) ? 32'h8000_0000 : 32'h0;
        endcase
        bus.in_valid  = iv;
        bus.in_data   = x;
        bus.out_ready = ordy;
        #1;
        exp_ready = !exp_valid || ordy;
        n_tests++;
        if (bus.in_ready !== exp_ready) begin
          n_fail++; $display("FAIL rnd_ready d=%0d cyc=%0d: got %b expected %b", d, cyc, bus.in_ready, exp_ready);
        end
        acc = iv && exp_ready;
        step();
        if (acc) begin
          hist.push_back(sm_to_int(x));
          if (hist.size() >= 2) exp_a1 = int_to_sm(clampv(hist[hist.size()-1] - hist[hist.size()-2]));
          exp_a0 = x;
          if (hist.size() > d) begin
            exp_valid = 1'b1;
            if (d == 0) begin
              exp_data = x;
              exp_sat  = 1'b0;
            end else begin
              v        = model_diff(d, s);
              exp_data = int_to_sm(v);
              exp_sat  = s;
            end
          end else begin
            exp_valid = 1'b0;
          end
        end else if (ordy) begin
          exp_valid = 1'b0;
        end
        n_tests++;
        if (bus.out_valid !== exp_valid ||
            (exp_valid && (bus.out_data !== exp_data || bus.out_sat !== exp_sat))) begin
          n_fail++; $display("FAIL rnd_out d=%0d cyc=%0d: got v=%b d=%h s=%b expected v=%b d=%h s=%b",
                             d, cyc, bus.out_valid, bus.out_data, bus.out_sat, exp_valid, exp_data, exp_sat);
        end
        n_tests++;
        if (anchor_0 !== exp_a0 || anchor_1 !== exp_a1) begin
          n_fail++; $display("FAIL rnd_anchor d=%0d cyc=%0d: got a0=%h a1=%h expected a0=%h a1=%h",
                             d, cyc, anchor_0, anchor_1, exp_a0, exp_a1);
        end
      end
      bus.in_valid = 1'b0;
    end
    bus.out_ready = 1'b1;
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b1;
    test_reset();
    test_order1();
    test_order2();
    test_backpressure();
    test_saturation();
    test_cfg_err();
    test_midstream_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
